// File: rtl/imem_fetch_port.sv
// Instruction memory with valid/ready fetch channel, LAT-stage response pipe.
// Optional per-word even parity: define IMEM_PARITY_EN.
module imem_fetch_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int LAT    = 1,
  parameter logic [DATA_W-1:0] RESET_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        rsp_fault,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int IW = ADDR_W - 2;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LIM = IW'(DEPTH);

  if (LAT < 1 || LAT > 3) begin : g_lat_bad
    $error("imem_fetch_port: LAT must be in 1..3");
  end

  typedef struct packed {
    logic              v;
    logic [2:0]        f;
    logic [DATA_W-1:0] d;
  } stg_t;

  logic [DATA_W-1:0] mem [DEPTH];
  stg_t              stg [LAT];

  logic [IW-1:0]     ridx;
  logic [IW-1:0]     widx;
  logic [MW-1:0]     ra;
  logic [MW-1:0]     wa;
  logic              r_in;
  logic              w_in;
  logic              stall;
  logic              accept;
  logic              perr;
  logic [DATA_W-1:0] rd_word;
  logic [2:0]        f_new;
  logic [DATA_W-1:0] d_new;
  logic              unused_wr_lsb;

  assign unused_wr_lsb = ^wr_addr[1:0];

  assign ridx = req_addr[ADDR_W-1:2];
  assign widx = wr_addr[ADDR_W-1:2];
  assign ra   = ridx[MW-1:0];
  assign wa   = widx[MW-1:0];
  assign r_in = ridx < LIM;
  assign w_in = widx < LIM;

  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = reset_n & ~wr_en & ~stall;
  assign accept    = req_valid & req_ready;

  assign rd_word = mem[ra];

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_mem[i] <= ^RESET_WORD;
      end
    end else if (wr_en && w_in) begin
      par_mem[wa] <= ^wr_data;
    end
  end

  // Only meaningful when the word was really read.
  assign perr = r_in & ~|req_addr[1:0]
              & (par_mem[ra] != ^rd_word);
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    f_new    = 3'b000;
    f_new[0] = |req_addr[1:0];
    f_new[1] = ~r_in;
    f_new[2] = perr;
    d_new    = rd_word;
    if (|f_new[1:0]) begin
      d_new = RESET_WORD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_WORD;
      end
    end else if (wr_en && w_in) begin
      mem[wa] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        stg[i] <= '{1'b0, 3'b000, RESET_WORD};
      end
    end else if (!stall) begin
      stg[0].v <= accept;
      if (accept) begin
        stg[0].f <= f_new;
        stg[0].d <= d_new;
      end
      for (int i = 1; i < LAT; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign rsp_valid = stg[LAT-1].v;
  assign rsp_data  = stg[LAT-1].d;
  assign rsp_fault = stg[LAT-1].f;

endmodule
